ask4_sym_slicer: RTL and testbench

Receive-side symbol recovery for the 4-ASK link. It takes the 18-bit sample-rate output of `srrc_gold_rx_flt` and decimates it to one sample per symbol at a selectable phase. It estimates the decision reference level from the mean absolute value, slices each sample to a 2-bit symbol, and reports the reconstructed level and the decision error. It is the demapper counterpart of the TX symbol source that drives `srrc_gold_tx_flt`.

---
 rtl/ask4_sym_slicer_if.sv | 13 +
 rtl/ask4_sym_slicer.sv | 186 ++++++++++++++++++
 tb/tb_ask4_sym_slicer.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ask4_sym_slicer_if.sv
// Symbol-rate decision bus driven by ask4_sym_slicer.
// The master drives decisions; slave is the downstream consumer view.
interface ask4_sym_slicer_if #(
    parameter int WIDTH = 18
);
    logic [1:0]              sym_out;
    logic                    sym_valid;
    logic signed [WIDTH-1:0] level_out;
    logic signed [WIDTH-1:0] err_out;

    modport master (output sym_out, sym_valid, level_out, err_out);
    modport slave  (input  sym_out, sym_valid, level_out, err_out);
endinterface

// File: rtl/ask4_sym_slicer.sv
// 4-ASK receive slicer: phase-selectable decimation, mean-|x| reference estimate,
// 2-bit decisions with level/error outputs. Optional block error power via SLICER_ERR_PWR_EN.
module ask4_sym_slicer #(
    parameter int WIDTH    = 18,
    parameter int LOG2_AVG = 10
) (
    input  logic                          sys_clk,
    input  logic                          reset,
    input  logic                          sam_clk_en,
    input  logic                          sym_clk_en,
    input  logic [1:0]                    phase_sel,
    input  logic signed [WIDTH-1:0]       rx_in,
    ask4_sym_slicer_if.master             sym_bus,
    output logic [WIDTH-1:0]              ref_level,
    output logic                          locked,
    output logic [2*WIDTH+LOG2_AVG-1:0]   err_pwr,
    output logic                          err_pwr_valid
);
    typedef enum logic {ACQ, TRACK} state_t;

    localparam logic signed [WIDTH-1:0] XMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] XMIN = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH:0] v);
        if (v[WIDTH] != v[WIDTH-1]) return v[WIDTH] ? XMIN : XMAX;
        return v[WIDTH-1:0];
    endfunction

    state_t                    state_q, state_d;
    logic [1:0]                sam_idx_q, sam_idx_d;
    logic [WIDTH+LOG2_AVG-1:0] acc_q, acc_d;
    logic [LOG2_AVG-1:0]       blk_q, blk_d;
    logic [WIDTH-1:0]          ref_q, ref_d;
    logic                      locked_q, locked_d;
    logic [1:0]                sym_q, sym_d;
    logic                      valid_q, valid_d;
    logic signed [WIDTH-1:0]   level_q, level_d;
    logic signed [WIDTH-1:0]   err_q, err_d;

    logic                      sample_ev;
    logic                      blk_end;
    logic [WIDTH-1:0]          abs_x;
    logic [WIDTH+LOG2_AVG-1:0] blk_sum;
    logic [1:0]                dec_sym;
    logic signed [WIDTH-1:0]   dec_level;
    logic signed [WIDTH-1:0]   dec_err;
    logic signed [WIDTH:0]     x_e, r_e, half_e, lvl_e;

    always_comb begin
        sam_idx_d = sam_idx_q;
        if (sam_clk_en) sam_idx_d = sym_clk_en ? 2'd0 : sam_idx_q + 2'd1;
    end

    assign sample_ev = sam_clk_en && (sam_idx_d == phase_sel);
    assign blk_end   = sample_ev && (&blk_q);

    // The most negative code has no positive twin, so it folds onto the maximum.
    assign abs_x   = !rx_in[WIDTH-1] ? rx_in : ((rx_in == XMIN) ? XMAX : -rx_in);
    assign blk_sum = acc_q + {{LOG2_AVG{1'b0}}, abs_x};

    always_comb begin
        x_e    = {rx_in[WIDTH-1], rx_in};
        r_e    = {1'b0, ref_q};
        half_e = {2'b00, ref_q[WIDTH-1:1]};
        if (x_e >= r_e) begin
            dec_sym = 2'b11;
            lvl_e   = r_e + half_e;
        end else if (!rx_in[WIDTH-1]) begin
            dec_sym = 2'b10;
            lvl_e   = half_e;
        end else if (x_e >= -r_e) begin
            dec_sym = 2'b01;
            lvl_e   = -half_e;
        end else begin
            dec_sym = 2'b00;
            lvl_e   = -(r_e + half_e);
        end
        dec_level = sat(lvl_e);
        dec_err   = sat(x_e - {dec_level[WIDTH-1], dec_level});
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        blk_d    = blk_q;
        ref_d    = ref_q;
        locked_d = locked_q;
        sym_d    = sym_q;
        level_d  = level_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        if (sample_ev) begin
            blk_d = blk_q + 1'b1;
            acc_d = blk_sum;
            // Decisions use the reference held before this cycle's block-end update.
            if (state_q == TRACK) begin
                sym_d   = dec_sym;
                level_d = dec_level;
                err_d   = dec_err;
                valid_d = 1'b1;
            end
            if (blk_end) begin
                ref_d    = blk_sum[WIDTH+LOG2_AVG-1:LOG2_AVG];
                acc_d    = '0;
                locked_d = 1'b1;
                state_d  = TRACK;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q   <= ACQ;
            sam_idx_q <= '0;
            acc_q     <= '0;
            blk_q     <= '0;
            ref_q     <= '0;
            locked_q  <= 1'b0;
            sym_q     <= '0;
            valid_q   <= 1'b0;
            level_q   <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            sam_idx_q <= sam_idx_d;
            acc_q     <= acc_d;
            blk_q     <= blk_d;
            ref_q     <= ref_d;
            locked_q  <= locked_d;
            sym_q     <= sym_d;
            valid_q   <= valid_d;
            level_q   <= level_d;
            err_q     <= err_d;
        end
    end

    assign sym_bus.sym_out   = sym_q;
    assign sym_bus.sym_valid = valid_q;
    assign sym_bus.level_out = level_q;
    assign sym_bus.err_out   = err_q;
    assign ref_level         = ref_q;
    assign locked            = locked_q;

`ifdef SLICER_ERR_PWR_EN
    localparam int PW = 2*WIDTH + LOG2_AVG;

    logic signed [2*WIDTH-1:0] err_sq;
    logic [PW-1:0]             pacc_q, pacc_d, pwr_q, pwr_d;
    logic                      pvalid_q, pvalid_d;

    assign err_sq = dec_err * dec_err;

    // Only TRACK decisions contribute, so the first report covers the first full TRACK block.
    always_comb begin
        pacc_d   = pacc_q;
        pwr_d    = pwr_q;
        pvalid_d = 1'b0;
        if (sample_ev && state_q == TRACK) pacc_d = pacc_q + {{LOG2_AVG{1'b0}}, err_sq};
        if (blk_end) begin
            pacc_d = '0;
            if (state_q == TRACK) begin
                pwr_d    = pacc_q + {{LOG2_AVG{1'b0}}, err_sq};
                pvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            pacc_q   <= '0;
            pwr_q    <= '0;
            pvalid_q <= 1'b0;
        end else begin
            pacc_q   <= pacc_d;
            pwr_q    <= pwr_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign err_pwr       = pwr_q;
    assign err_pwr_valid = pvalid_q;
`else
    assign err_pwr       = '0;
    assign err_pwr_valid = 1'b0;
`endif
endmodule

// File: tb/tb_ask4_sym_slicer.sv
// Self-checking bench for ask4_sym_slicer (LOG2_AVG=4) against an integer reference model.
// Error-power expectations follow SLICER_ERR_PWR_EN when it is defined for the build.
module tb_ask4_sym_slicer;
    localparam int W = 18;
    localparam int L = 4;
    localparam int NBLK = 1 << L;
    localparam int SMAX = (1 << (W-1)) - 1;
    localparam int SMIN = -(1 << (W-1));

    logic                  sys_clk = 1'b0;
    logic                  reset;
    logic                  sam_clk_en;
    logic                  sym_clk_en;
    logic [1:0]            phase_sel;
    logic signed [W-1:0]   rx_in;
    logic [W-1:0]          ref_level;
    logic                  locked;
    logic [2*W+L-1:0]      err_pwr;
    logic                  err_pwr_valid;

    ask4_sym_slicer_if #(.WIDTH(W)) sif ();

    ask4_sym_slicer #(.WIDTH(W), .LOG2_AVG(L)) dut (
        .sys_clk       (sys_clk),
        .reset         (reset),
        .sam_clk_en    (sam_clk_en),
        .sym_clk_en    (sym_clk_en),
        .phase_sel     (phase_sel),
        .rx_in         (rx_in),
        .sym_bus       (sif),
        .ref_level     (ref_level),
        .locked        (locked),
        .err_pwr       (err_pwr),
        .err_pwr_valid (err_pwr_valid)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int     m_idx, m_cnt;
    longint m_sum, m_pacc;
    bit     m_track;
    int     e_sym, e_level, e_err, e_ref, e_vcnt, e_pulses;
    bit     e_locked;
    longint e_pwr;

    // Observed snapshots
    logic [1:0]          o_sym;
    logic signed [W-1:0] o_level, o_err;
    logic [W-1:0]        o_ref;
    logic                o_locked;
    logic [2*W+L-1:0]    o_pwr;
    int                  o_vcnt, o_pulses;

    function automatic int clampw(input int v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_cnt = 0; m_sum = 0; m_pacc = 0; m_track = 0;
        e_sym = 0; e_level = 0; e_err = 0; e_ref = 0; e_locked = 0; e_pwr = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1; sam_clk_en = 1'b0; sym_clk_en = 1'b0;
        @(posedge sys_clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic snap();
        o_sym = sif.sym_out; o_level = sif.level_out; o_err = sif.err_out;
        o_ref = ref_level; o_locked = locked; o_pwr = err_pwr;
        o_vcnt += int'(sif.sym_valid);
        o_pulses += int'(err_pwr_valid);
    endtask

    task automatic drive_sample(input int x, input bit first);
        int ax, r, lvl;
        logic [31:0] rnd;
        rx_in = x[W-1:0];
        sam_clk_en = 1'b1;
        sym_clk_en = first;
        m_idx = first ? 0 : (m_idx + 1) % 4;
        if (m_idx == int'(phase_sel)) begin
            ax = (x < 0) ? ((x == SMIN) ? SMAX : -x) : x;
            if (m_track) begin
                r = e_ref;
                if (x >= r)       begin e_sym = 3; lvl = clampw(r + r/2); end
                else if (x >= 0)  begin e_sym = 2; lvl = r/2; end
                else if (x >= -r) begin e_sym = 1; lvl = -(r/2); end
                else              begin e_sym = 0; lvl = clampw(-(r + r/2)); end
                e_level = lvl;
                e_err = clampw(x - lvl);
                e_vcnt++;
                m_pacc += longint'(e_err) * longint'(e_err);
            end
            m_sum += ax;
            m_cnt++;
            if (m_cnt == NBLK) begin
                e_ref = int'(m_sum / NBLK);
                m_sum = 0; m_cnt = 0;
                e_locked = 1;
`ifdef SLICER_ERR_PWR_EN
                if (m_track) begin e_pwr = m_pacc; e_pulses++; end
`endif
                m_pacc = 0;
                m_track = 1;
            end
        end
        @(posedge sys_clk); #1;
        snap();
        rnd = $urandom;
        sam_clk_en = 1'b0;
        sym_clk_en = rnd[31];
        rx_in = rnd[W-1:0];
        @(posedge sys_clk); #1;
        snap();
        sym_clk_en = 1'b0;
    endtask

    task automatic drive_symbol(input int a, input int b, input int c, input int d);
        o_vcnt = 0; e_vcnt = 0;
        drive_sample(a, 1'b1);
        drive_sample(b, 1'b0);
        drive_sample(c, 1'b0);
        drive_sample(d, 1'b0);
    endtask

    task automatic test_reset();
        phase_sel = 2'd0; rx_in = '0;
        apply_reset();
        checks++;
        if (sif.sym_out !== 2'd0 || sif.sym_valid !== 1'b0 || sif.level_out !== '0 || sif.err_out !== '0 ||
            ref_level !== '0 || locked !== 1'b0 || err_pwr !== '0 || err_pwr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset: got sym=%0d v=%0b lvl=%0d err=%0d ref=%0d lock=%0b pwr=%0d pv=%0b, need all 0",
                     sif.sym_out, sif.sym_valid, sif.level_out, sif.err_out, ref_level, locked, err_pwr, err_pwr_valid);
        end
    endtask

    task automatic test_acquire_slice();
        int pat[4] = '{24576, 8192, -8192, -24576};
        int want_sym[4] = '{3, 2, 1, 0};
        phase_sel = 2'd0;
        apply_reset();
        for (int s = 0; s < NBLK + 8; s++) begin
            drive_symbol(pat[s%4], pat[s%4], pat[s%4], pat[s%4]);
            checks++;
            if (o_sym !== e_sym || o_level !== e_level || o_err !== e_err || o_vcnt !== e_vcnt ||
                o_ref !== e_ref || o_locked !== e_locked) begin
                errors++;
                $display("FAIL acq_slice sym %0d: got sym=%0d lvl=%0d err=%0d v=%0d ref=%0d lock=%0b need %0d %0d %0d %0d %0d %0b",
                         s, o_sym, o_level, o_err, o_vcnt, o_ref, o_locked, e_sym, e_level, e_err, e_vcnt, e_ref, e_locked);
            end
            if (s == NBLK - 1) begin
                checks++;
                if (o_ref !== 16384 || o_locked !== 1'b1) begin
                    errors++;
                    $display("FAIL acq_lock: got ref=%0d lock=%0b need 16384 1", o_ref, o_locked);
                end
            end
            if (s >= NBLK) begin
                checks++;
                if (o_sym !== want_sym[s%4] || o_level !== pat[s%4] || o_err !== 0) begin
                    errors++;
                    $display("FAIL acq_ideal sym %0d: got sym=%0d lvl=%0d err=%0d need %0d %0d 0",
                             s, o_sym, o_level, o_err, want_sym[s%4], pat[s%4]);
                end
            end
        end
    endtask

    task automatic test_phase_select();
        phase_sel = 2'd2;
        apply_reset();
        for (int s = 0; s < NBLK + 4; s++) begin
            drive_symbol(0, 0, 24576, 0);
            checks++;
            if (o_sym !== e_sym || o_level !== e_level || o_err !== e_err || o_vcnt !== e_vcnt || o_ref !== e_ref) begin
                errors++;
                $display("FAIL phase2 sym %0d: got sym=%0d lvl=%0d err=%0d v=%0d ref=%0d need %0d %0d %0d %0d %0d",
                         s, o_sym, o_level, o_err, o_vcnt, o_ref, e_sym, e_level, e_err, e_vcnt, e_ref);
            end
            if (s >= NBLK) begin
                checks++;
                if (o_ref !== 24576 || o_sym !== 2'b11) begin
                    errors++;
                    $display("FAIL phase2_const sym %0d: got ref=%0d sym=%0d need 24576 3", s, o_ref, o_sym);
                end
            end
        end
        phase_sel = 2'd1;
        apply_reset();
        for (int s = 0; s < NBLK; s++) drive_symbol(0, 0, 24576, 0);
        checks++;
        if (o_ref !== 0 || o_locked !== 1'b1 || o_ref !== e_ref) begin
            errors++;
            $display("FAIL phase1: got ref=%0d lock=%0b need 0 1", o_ref, o_locked);
        end
    endtask

    task automatic test_threshold();
        int tin[6]  = '{16384, 16383, 0, -1, -16384, -16385};
        int tsym[6] = '{3, 2, 2, 1, 1, 0};
        int pat[4]  = '{24576, 8192, -8192, -24576};
        phase_sel = 2'd0;
        apply_reset();
        for (int s = 0; s < NBLK; s++) drive_symbol(pat[s%4], pat[s%4], pat[s%4], pat[s%4]);
        for (int i = 0; i < 6; i++) begin
            drive_symbol(tin[i], tin[i], tin[i], tin[i]);
            checks++;
            if (o_sym !== tsym[i] || o_sym !== e_sym || o_level !== e_level || o_err !== e_err || o_vcnt !== 1) begin
                errors++;
                $display("FAIL threshold x=%0d: got sym=%0d lvl=%0d err=%0d v=%0d need %0d %0d %0d 1",
                         tin[i], o_sym, o_level, o_err, o_vcnt, tsym[i], e_level, e_err);
            end
        end
    endtask

    task automatic test_saturation();
        phase_sel = 2'd0;
        apply_reset();
        for (int s = 0; s < NBLK + 4; s++) begin
            drive_symbol(SMIN, SMIN, SMIN, SMIN);
            if (s >= NBLK) begin
                checks++;
                if (o_ref !== 131071 || o_sym !== 2'b00 || o_level !== -131072 || o_err !== 0 || o_level !== e_level) begin
                    errors++;
                    $display("FAIL saturation sym %0d: got ref=%0d sym=%0d lvl=%0d err=%0d need 131071 0 -131072 0",
                             s, o_ref, o_sym, o_level, o_err);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int pat[4] = '{24576, 8192, -8192, -24576};
        phase_sel = 2'd0;
        apply_reset();
        for (int s = 0; s < NBLK + 8; s++) drive_symbol(pat[s%4], pat[s%4], pat[s%4], pat[s%4]);
        drive_sample(pat[0], 1'b1);
        drive_sample(pat[0], 1'b0);
        apply_reset();
        checks++;
        if (sif.sym_out !== 2'd0 || sif.sym_valid !== 1'b0 || sif.level_out !== '0 || sif.err_out !== '0 ||
            ref_level !== '0 || locked !== 1'b0 || err_pwr !== '0 || err_pwr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got sym=%0d lvl=%0d err=%0d ref=%0d lock=%0b pwr=%0d, need all 0",
                     sif.sym_out, sif.level_out, sif.err_out, ref_level, locked, err_pwr);
        end
        for (int s = 0; s < NBLK; s++) begin
            drive_symbol(pat[s%4], pat[s%4], pat[s%4], pat[s%4]);
            checks++;
            if (o_locked !== ((s == NBLK - 1) ? 1'b1 : 1'b0) || o_vcnt !== 0 || o_ref !== e_ref) begin
                errors++;
                $display("FAIL relock sym %0d: got lock=%0b v=%0d ref=%0d need %0b 0 %0d",
                         s, o_locked, o_vcnt, o_ref, (s == NBLK - 1), e_ref);
            end
        end
    endtask

    task automatic test_err_pwr();
        int pat[4] = '{24676, 8292, -8092, -24476};
        phase_sel = 2'd0;
        apply_reset();
        o_pulses = 0; e_pulses = 0;
        for (int s = 0; s < 3 * NBLK; s++) begin
            drive_symbol(pat[s%4], pat[s%4], pat[s%4], pat[s%4]);
            checks++;
            if (o_pwr !== e_pwr || o_pulses !== e_pulses || o_err !== e_err) begin
                errors++;
                $display("FAIL err_pwr sym %0d: got pwr=%0d pulses=%0d err=%0d need %0d %0d %0d",
                         s, o_pwr, o_pulses, o_err, e_pwr, e_pulses, e_err);
            end
        end
`ifdef SLICER_ERR_PWR_EN
        checks++;
        if (o_pwr !== 160000 || o_pulses !== 2) begin
            errors++;
            $display("FAIL err_pwr_const: got pwr=%0d pulses=%0d need 160000 2", o_pwr, o_pulses);
        end
`endif
    endtask

    task automatic test_random();
        int v[4];
        logic [31:0] rnd;
        phase_sel = 2'd0;
        apply_reset();
        o_pulses = 0; e_pulses = 0;
        for (int s = 0; s < 200; s++) begin
            if (s % 13 == 12) phase_sel = 2'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) begin
                rnd = $urandom;
                if (rnd[3:0] == 4'd0) v[k] = clampw(int'($urandom_range(0, 262143)) - 131072);
                else v[k] = (2 * int'(rnd[5:4]) - 3) * 8192 + int'($urandom_range(0, 4000)) - 2000;
            end
            drive_symbol(v[0], v[1], v[2], v[3]);
            checks++;
            if (o_sym !== e_sym || o_level !== e_level || o_err !== e_err || o_vcnt !== e_vcnt ||
                o_ref !== e_ref || o_locked !== e_locked || o_pwr !== e_pwr || o_pulses !== e_pulses) begin
                errors++;
                $display("FAIL random sym %0d: got sym=%0d lvl=%0d err=%0d v=%0d ref=%0d lock=%0b pwr=%0d pc=%0d need %0d %0d %0d %0d %0d %0b %0d %0d",
                         s, o_sym, o_level, o_err, o_vcnt, o_ref, o_locked, o_pwr, o_pulses,
                         e_sym, e_level, e_err, e_vcnt, e_ref, e_locked, e_pwr, e_pulses);
            end
        end
    endtask

    initial begin
        reset = 1'b1; sam_clk_en = 1'b0; sym_clk_en = 1'b0; phase_sel = 2'd0; rx_in = '0;
        o_vcnt = 0; o_pulses = 0; e_vcnt = 0; e_pulses = 0;
        model_reset();
        test_reset();
        test_acquire_slice();
        test_phase_select();
        test_threshold();
        test_saturation();
        test_reset_mid();
        test_err_pwr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
